// File: rtl/pipeline_trace_recorder.sv
// Producer side of the pipeline trace path: shadows IF/ID/EX/MEM/WB occupancy and queues
// one record per retirement into a FWFT FIFO. Optional stall counting: TRACE_STALL_CNT_EN.
module pipeline_trace_recorder #(
  parameter int PC_W       = 16,
  parameter int INSTR_W    = 16,
  parameter int CYC_W      = 32,
  parameter int SEQ_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               stall,
  input  logic               flush,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [SEQ_W-1:0]   rec_seq,
  output logic [PC_W-1:0]    rec_pc,
  output logic [INSTR_W-1:0] rec_instr,
  output logic [CYC_W-1:0]   rec_fetch_cyc,
  output logic [CYC_W-1:0]   rec_retire_cyc,
`ifdef TRACE_STALL_CNT_EN
  output logic [7:0]         rec_stalls,
`endif
  output logic [15:0]        overflow_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CYC_W-1:0]   fetch_cyc;
`ifdef TRACE_STALL_CNT_EN
    logic [7:0]         stalls;
`endif
  } slot_t;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [CYC_W-1:0]   fetch_cyc;
    logic [CYC_W-1:0]   retire_cyc;
`ifdef TRACE_STALL_CNT_EN
    logic [7:0]         stalls;
`endif
  } rec_t;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  slot_t            id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [15:0]      ovf_q, ovf_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  rec_t             fifo_q [FIFO_DEPTH];
  rec_t             fifo_d [FIFO_DEPTH];

  logic [PTR_W:0] count;
  logic           empty, full, pop, push, push_ok;
  rec_t           new_rec, head;

  // Valid/ready: a record transfers on any edge where rec_valid && rec_ready; while
  // rec_valid is high and rec_ready low the head record is held unchanged.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop     = !empty && rec_ready;
  assign push    = wb_q.valid;
  // A pop on the same edge frees the slot that a push into a full FIFO needs.
  assign push_ok = push && (!full || pop);

  always_comb begin
    cyc_d = cyc_q + 1'b1;
    id_d  = id_q;
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (flush) begin
      id_d = '0;
    end else if (stall) begin
`ifdef TRACE_STALL_CNT_EN
      if (id_q.valid && id_q.stalls != 8'hFF) id_d.stalls = id_q.stalls + 1'b1;
`endif
    end else begin
      ex_d = id_q;
      id_d = '0;
      if (if_valid) begin
        id_d.valid     = 1'b1;
        id_d.pc        = if_pc;
        id_d.instr     = if_instr;
        id_d.fetch_cyc = cyc_q;
      end
    end
  end

  always_comb begin
    new_rec            = '0;
    new_rec.seq        = seq_q;
    new_rec.pc         = wb_q.pc;
    new_rec.instr      = wb_q.instr;
    new_rec.fetch_cyc  = wb_q.fetch_cyc;
    new_rec.retire_cyc = cyc_q;
`ifdef TRACE_STALL_CNT_EN
    new_rec.stalls     = wb_q.stalls;
`endif

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = new_rec;
      wr_ptr_d = wr_ptr_q + 1'b1;
      seq_d    = seq_q + 1'b1;
    end else if (push && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q    <= '0;
      id_q     <= '0;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      seq_q    <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      cyc_q    <= cyc_d;
      id_q     <= id_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  // Fields read as zero whenever nothing is queued.
  assign head           = empty ? '0 : fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign rec_valid      = !empty;
  assign rec_seq        = head.seq;
  assign rec_pc         = head.pc;
  assign rec_instr      = head.instr;
  assign rec_fetch_cyc  = head.fetch_cyc;
  assign rec_retire_cyc = head.retire_cyc;
`ifdef TRACE_STALL_CNT_EN
  assign rec_stalls     = head.stalls;
`endif
  assign overflow_cnt   = ovf_q;

endmodule

// File: tb/tb_pipeline_trace_recorder.sv
// Directed bench for pipeline_trace_recorder: latency, stall, flush, overflow,
// full-FIFO push/pop and mid-operation reset with hand-computed records.
module tb_pipeline_trace_recorder;

  logic        clk, rst;
  logic        if_valid, stall, flush, rec_ready;
  logic [15:0] if_pc, if_instr;
  logic        rec_valid;
  logic [15:0] rec_seq, rec_pc, rec_instr, overflow_cnt;
  logic [31:0] rec_fetch_cyc, rec_retire_cyc;
`ifdef TRACE_STALL_CNT_EN
  logic [7:0]  rec_stalls;
`endif

  int checks = 0;
  int errors = 0;
  int tb_cyc = 0;
  logic [63:0] exp_q[$];

  pipeline_trace_recorder dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall(stall), .flush(flush), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_seq(rec_seq), .rec_pc(rec_pc), .rec_instr(rec_instr),
    .rec_fetch_cyc(rec_fetch_cyc), .rec_retire_cyc(rec_retire_cyc),
`ifdef TRACE_STALL_CNT_EN
    .rec_stalls(rec_stalls),
`endif
    .overflow_cnt(overflow_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, tb_cyc);
    end
  endtask

  task automatic check_rec(input string tag, input logic [63:0] seq, input logic [63:0] pc,
                           input logic [63:0] instr, input logic [63:0] fcyc,
                           input logic [63:0] rcyc);
    check({tag, "_valid"},  64'(rec_valid), 64'h1);
    check({tag, "_seq"},    64'(rec_seq), seq);
    check({tag, "_pc"},     64'(rec_pc), pc);
    check({tag, "_instr"},  64'(rec_instr), instr);
    check({tag, "_fetch"},  64'(rec_fetch_cyc), fcyc);
    check({tag, "_retire"}, 64'(rec_retire_cyc), rcyc);
  endtask

  // driver tasks: inputs change at the falling edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    tb_cyc++;
  endtask

  task automatic run_to(input int n);
    while (tb_cyc < n) tick();
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    tick();
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    stall = 1'b0; flush = 1'b0; rec_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_cyc = 0;
  endtask

  initial begin
    // 1: reset values and single-instruction latency
    do_reset();
    check("rst_valid", 64'(rec_valid), 64'h0);
    check("rst_seq", 64'(rec_seq), 64'h0);
    check("rst_pc", 64'(rec_pc), 64'h0);
    check("rst_fetch", 64'(rec_fetch_cyc), 64'h0);
    check("rst_retire", 64'(rec_retire_cyc), 64'h0);
    check("rst_ovf", 64'(overflow_cnt), 64'h0);
    rec_ready = 1'b1;
    run_to(3);
    fetch(16'h0010, 16'hA123);
    run_to(7);
    check("t1_not_early", 64'(rec_valid), 64'h0);
    tick();
    check_rec("t1", 64'h0, 64'h0010, 64'hA123, 64'd3, 64'd7);
`ifdef TRACE_STALL_CNT_EN
    check("t1_stalls", 64'(rec_stalls), 64'h0);
`endif
    tick();
    check("t1_drained", 64'(rec_valid), 64'h0);
    check("t1_empty_pc", 64'(rec_pc), 64'h0);

    // 2: two stall cycles while the instruction sits in ID
    do_reset();
    rec_ready = 1'b1;
    run_to(3);
    fetch(16'h0020, 16'hB456);
    stall = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    run_to(9);
    check("t2_not_early", 64'(rec_valid), 64'h0);
    tick();
    check_rec("t2", 64'h0, 64'h0020, 64'hB456, 64'd3, 64'd9);
`ifdef TRACE_STALL_CNT_EN
    check("t2_stalls", 64'(rec_stalls), 64'd2);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_no_extra", 64'(rec_valid), 64'h0);
    end

    // 3: flush kills ID and the IF capture of the same cycle
    do_reset();
    rec_ready = 1'b1;
    run_to(3);
    fetch(16'h0030, 16'hC001);
    fetch(16'h0032, 16'hC002);
    flush = 1'b1;
    fetch(16'h0034, 16'hC003);
    flush = 1'b0;
    run_to(8);
    check_rec("t3", 64'h0, 64'h0030, 64'hC001, 64'd3, 64'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_killed", 64'(rec_valid), 64'h0);
    end

    // 4: six retirements into a stalled consumer
    do_reset();
    run_to(3);
    for (int i = 0; i < 6; i++) begin
      fetch(16'(64 + 2 * i), 16'(16'hD000 + i));
      if (i < 4) exp_q.push_back(64'(64 + 2 * i));
    end
    run_to(11);
    check("t4_hold_pc", 64'(rec_pc), 64'h40);
    check("t4_ovf_pre", 64'(overflow_cnt), 64'h0);
    tick();
    check("t4_ovf_one", 64'(overflow_cnt), 64'h1);
    run_to(13);
    check("t4_ovf", 64'(overflow_cnt), 64'h2);
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_rec($sformatf("t4_drain%0d", i), 64'(i), exp_q.pop_front(),
                64'(16'hD000 + i), 64'(3 + i), 64'(7 + i));
      tick();
    end
    check("t4_empty", 64'(rec_valid), 64'h0);
    check("t4_ovf_kept", 64'(overflow_cnt), 64'h2);

    // 5: retire into a full FIFO on the same edge as a pop
    do_reset();
    run_to(3);
    for (int i = 0; i < 5; i++) fetch(16'(80 + 2 * i), 16'(16'hE000 + i));
    run_to(11);
    check("t5_full_head", 64'(rec_seq), 64'h0);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    check("t5_ovf", 64'(overflow_cnt), 64'h0);
    rec_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_rec($sformatf("t5_drain%0d", i), 64'(i), 64'(80 + 2 * i),
                64'(16'hE000 + i), 64'(3 + i), 64'(7 + i));
      tick();
    end
    check("t5_empty", 64'(rec_valid), 64'h0);

    // 6: reset with three in flight and two queued
    do_reset();
    run_to(3);
    for (int i = 0; i < 5; i++) fetch(16'(96 + 2 * i), 16'(16'hF000 + i));
    run_to(9);
    check("t6_queued", 64'(rec_pc), 64'h60);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_valid", 64'(rec_valid), 64'h0);
    check("t6_rst_pc", 64'(rec_pc), 64'h0);
    check("t6_rst_ovf", 64'(overflow_cnt), 64'h0);
    rst = 1'b0;
    tb_cyc = 0;
    rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_discarded", 64'(rec_valid), 64'h0);
    end
    fetch(16'h0070, 16'h7777);
    run_to(7);
    check("t6_not_early", 64'(rec_valid), 64'h0);
    tick();
    check_rec("t6", 64'h0, 64'h0070, 64'h7777, 64'd3, 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
